// File: rtl/xfer_sequencer.sv
// -----------------------------------------------------------------------------
// xfer_sequencer
//
// Controller for the memory-to-memory transfer datapath. It has two phases.
//  - Fill: memory A is written from DataInA, one word per accepted
//    valid/ready beat.
//  - Pairs: memory A is read two words at a time. Each pair produces one word
//    in memory B. The word is the difference when the first operand is larger,
//    and the sum otherwise.
// The datapath returns only the compare flag. Every strobe is a combinational
// decode of the present state and the inputs. The two address counters are
// the only other state.
//
// Ports
//   clock    in   rising-edge clock
//   Reset    in   asynchronous active-low reset
//   start    in   begin a transfer (sampled only in IDLE)
//   abort    in   synchronous return to IDLE, clears both counters
//   in_valid in   DataInA holds a word for memory A
//   cmp_gt   in   DOut1 > DOut2 (unsigned), from the datapath
//   in_ready out  word accepted this cycle (FILL only)
//   WEA      out  memory A write enable
//   IncA     out  AddrA advances at the next edge
//   AddrA    out  memory A address
//   ld1/ld2  out  load DOut1 / DOut2 from memory A read data
//   WEB      out  memory B write enable
//   IncB     out  AddrB advances at the next edge
//   AddrB    out  memory B address
//   sel_sub  out  1: B takes SUBOut, 0: B takes ADDOut
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   ps       out  present state code, for debug
// -----------------------------------------------------------------------------
module xfer_sequencer #(
  parameter int A_AW = 3,
  parameter int B_AW = 2
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic            cmp_gt,
  output logic            in_ready,
  output logic            WEA,
  output logic            IncA,
  output logic [A_AW-1:0] AddrA,
  output logic            ld1,
  output logic            ld2,
  output logic            WEB,
  output logic            IncB,
  output logic [B_AW-1:0] AddrB,
  output logic            sel_sub,
  output logic            busy,
  output logic            done,
  output logic [2:0]      ps
);

  // Each pair of A words produces one B word, so B must have half A's depth.
  if (B_AW != A_AW - 1) begin : g_bad_widths
    $error("xfer_sequencer: B_AW must equal A_AW-1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [A_AW-1:0] A_LAST = '1;
  localparam logic [B_AW-1:0] B_LAST = '1;

  state_t state_q, state_d;
  logic   clr_cnt;

  // NOTE: state and counters use non-blocking assignments, so every reader
  // sees the pre-edge value. Blocking assignments here would make the result
  // depend on process ordering.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      AddrA   <= '0;
      AddrB   <= '0;
    end else begin
      state_q <= state_d;
      if (clr_cnt) begin
        AddrA <= '0;
        AddrB <= '0;
      end else begin
        // Both counters wrap naturally, so no explicit reload is needed at the
        // end of a phase.
        if (IncA) AddrA <= AddrA + 1'b1;
        if (IncB) AddrB <= AddrB + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default value first. A path that
  // forgets one signal then yields 0 instead of an inferred latch.
  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    in_ready = 1'b0;
    WEA      = 1'b0;
    IncA     = 1'b0;
    ld1      = 1'b0;
    ld2      = 1'b0;
    WEB      = 1'b0;
    IncB     = 1'b0;
    sel_sub  = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        clr_cnt = 1'b1;
        if (start) state_d = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          WEA  = 1'b1;
          IncA = 1'b1;
          if (AddrA == A_LAST) state_d = RD1;
        end
      end
      RD1: begin
        ld1     = 1'b1;
        IncA    = 1'b1;
        state_d = RD2;
      end
      RD2: begin
        ld2     = 1'b1;
        IncA    = 1'b1;
        state_d = WR;
      end
      WR: begin
        WEB     = 1'b1;
        sel_sub = cmp_gt;
        IncB    = 1'b1;
        state_d = (AddrB == B_LAST) ? DONE : RD1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;  // codes 6 and 7 are unreachable
    endcase

    // Abort overrides everything. No write lands, no word is accepted, done
    // does not pulse, and the counters restart from zero.
    if (abort) begin
      state_d  = IDLE;
      clr_cnt  = 1'b1;
      in_ready = 1'b0;
      WEA      = 1'b0;
      IncA     = 1'b0;
      ld1      = 1'b0;
      ld2      = 1'b0;
      WEB      = 1'b0;
      IncB     = 1'b0;
      sel_sub  = 1'b0;
      done     = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);
  assign ps   = state_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xfer_sequencer
//
// Bench for xfer_sequencer. It includes a behavioural model of the datapath:
// memory A, the DOut1/DOut2 registers and the add/sub unit. The compare flag
// comes from that model.
//
// For each run, the expected memory B writes are pushed into a scoreboard
// queue. A negedge monitor pops and checks one entry for every WEB it sees.
// The driving task checks timing, busy, done and the address counters.
// -----------------------------------------------------------------------------
module tb_xfer_sequencer;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       cmp_gt;
  logic [7:0] DataInA = '0;

  logic       in_ready, WEA, IncA, ld1, ld2, WEB, IncB, sel_sub, busy, done;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic [2:0] ps;

  xfer_sequencer #(.A_AW(3), .B_AW(2)) dut (
    .clock(clock), .Reset(Reset), .start(start), .abort(abort),
    .in_valid(in_valid), .cmp_gt(cmp_gt), .in_ready(in_ready), .WEA(WEA),
    .IncA(IncA), .AddrA(AddrA), .ld1(ld1), .ld2(ld2), .WEB(WEB), .IncB(IncB),
    .AddrB(AddrB), .sel_sub(sel_sub), .busy(busy), .done(done), .ps(ps)
  );

  always #5 clock = ~clock;

  // ---------------- datapath model ----------------
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [4];
  logic [7:0] dout1 = '0, dout2 = '0;

  assign cmp_gt = (dout1 > dout2);

  always @(posedge clock) begin
    if (WEA) mem_a[AddrA] <= DataInA;
    if (ld1) dout1 <= mem_a[AddrA];
    if (ld2) dout2 <= mem_a[AddrA];
    if (WEB) mem_b[AddrB] <= sel_sub ? dout1 - dout2 : dout1 + dout2;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
    logic       sel;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_wr [4];
  logic [7:0] din [8];

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (Reset && WEB) begin
      if (sb.size() == 0) begin
        check("unexpected_web", 1, 0);
      end else begin
        wr_t        e;
        logic [7:0] r;
        e = sb.pop_front();
        r = sel_sub ? dout1 - dout2 : dout1 + dout2;
        check("b_addr", int'(AddrB), int'(e.addr));
        check("b_sel", int'(sel_sub), int'(e.sel));
        check("b_data", int'(r), int'(e.data));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Call this task just after a posedge. The current cycle is cycle 0, and
  // start is raised in it. A parameter set to 0 or -1 disables that feature.
  task automatic run_xfer(input bit gaps, input int exp_done, input int n_wr,
                          input int abort_cyc, input int reset_cyc,
                          input int pulse_a, input int pulse_b);
    int idx = 0, exp_a = 0, done_cyc = -1, ndone = 0, last, busy_until;
    for (int i = 0; i < n_wr; i++) sb.push_back(exp_wr[i]);
    last       = (exp_done > 0) ? exp_done + 1 : 32;
    busy_until = (abort_cyc > 0) ? abort_cyc : (reset_cyc > 0) ? reset_cyc : exp_done;
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clock); #1;
      start    = (c == pulse_a) || (c == pulse_b);
      abort    = (c == abort_cyc);
      in_valid = (idx < 8) && (!gaps || (c % 2 == 0));
      DataInA  = din[(idx < 8) ? idx : 7];
      if (c == reset_cyc) begin
        check("addra_pre_reset", int'(AddrA), exp_a);
        Reset = 1'b0;
        #1;
        check("rst_ps", int'(ps), 0);
        check("rst_addra", int'(AddrA), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wea", int'(WEA), 0);
        check("rst_inca", int'(IncA), 0);
        check("rst_busy", int'(busy), 0);
        in_valid = 1'b0;
        start    = 1'b0;
        @(posedge clock); #1;
        Reset = 1'b1;
        return;
      end
      @(negedge clock);
      check("busy", int'(busy), int'(c <= busy_until));
      if (ps == 3'd1) begin
        check("fill_wea", int'(WEA), int'(in_valid));
        check("fill_addra", int'(AddrA), exp_a);
      end
      if (abort_cyc > 0 && c == abort_cyc) check("abort_web", int'(WEB), 0);
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        check("abort_ps", int'(ps), 0);
        check("abort_addra", int'(AddrA), 0);
        check("abort_addrb", int'(AddrB), 0);
      end
      if (in_valid && in_ready) begin
        idx++;
        exp_a = (exp_a + 1) % 8;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
      end
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    check("done_count", ndone, (exp_done > 0) ? 1 : 0);
    if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
    check("end_addra", int'(AddrA), 0);
    check("end_addrb", int'(AddrB), 0);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic set_ramp(input bit down);
    for (int i = 0; i < 8; i++) din[i] = down ? 8'(7 - i) : 8'(i);
    for (int i = 0; i < 4; i++) begin
      exp_wr[i].addr = 2'(i);
      exp_wr[i].data = down ? 8'd1 : 8'(4 * i + 1);
      exp_wr[i].sel  = down;
    end
  endtask

  initial begin
    #1;
    check("reset_ps", int'(ps), 0);
    check("reset_addra", int'(AddrA), 0);
    check("reset_addrb", int'(AddrB), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_done", int'(done), 0);
    #12 Reset = 1'b1;
    @(posedge clock); #1;

    // 1: ascending data, continuous fill
    set_ramp(1'b0);
    run_xfer(1'b0, 21, 4, 0, 0, -1, -1);

    // 2: descending data, every pair subtracts
    @(posedge clock); #1;
    set_ramp(1'b1);
    run_xfer(1'b0, 21, 4, 0, 0, -1, -1);

    // 3: in_valid low on every other fill cycle, starting with a gap
    @(posedge clock); #1;
    set_ramp(1'b0);
    run_xfer(1'b1, 29, 4, 0, 0, -1, -1);

    // 4: abort in RD2 of the second pair; only the first pair writes B
    @(posedge clock); #1;
    set_ramp(1'b0);
    run_xfer(1'b0, -1, 1, 13, 0, -1, -1);
    @(posedge clock); #1;
    run_xfer(1'b0, 21, 4, 0, 0, -1, -1);

    // 5: reset in the middle of FILL, then an equal-operand pair
    @(posedge clock); #1;
    run_xfer(1'b0, -1, 0, 0, 6, -1, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_reset_idle", int'(ps), 0);
    end
    @(posedge clock); #1;
    din[0] = 8'd3;  din[1] = 8'd3;   din[2] = 8'd10; din[3] = 8'd2;
    din[4] = 8'd0;  din[5] = 8'd0;   din[6] = 8'd1;  din[7] = 8'd200;
    exp_wr[0] = '{addr: 2'd0, data: 8'd6,   sel: 1'b0};
    exp_wr[1] = '{addr: 2'd1, data: 8'd8,   sel: 1'b1};
    exp_wr[2] = '{addr: 2'd2, data: 8'd0,   sel: 1'b0};
    exp_wr[3] = '{addr: 2'd3, data: 8'd201, sel: 1'b0};
    run_xfer(1'b0, 21, 4, 0, 0, -1, -1);

    // 6: start pulses during FILL and WR are ignored
    @(posedge clock); #1;
    set_ramp(1'b0);
    run_xfer(1'b0, 21, 4, 0, 0, 4, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
